sparse_chunk_sram_receiver: RTL and testbench
=============================================

Name: sparse_chunk_sram_receiver

Overview:
- Receiving end of the compressed-chunk SRAM write interface: sparsemap plus packed nonzero-data beats, tagged with beat count and chunk count.
- Stores beats into an internal chunk buffer and tracks chunk boundaries and beat sequencing.
- Accumulates the per-chunk nonzero count and publishes chunk-ready status.
- Serves a 1-cycle-latency read port to the compute side. One instance is used per IFM stream and one per filter stream.

Parameters:
- BUS_SIZE, 16, lanes per beat (sparsemap bits per beat).
- DAT_SIZE, 8, bits per data lane.
- CHUNK_NUM, 4, chunks held in the buffer.
- BEAT_NUM, 4, maximum beats per chunk.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- wr_valid_i  in  1  write beat valid.
- wr_sparsemap_i  in  BUS_SIZE  sparsemap slice for this beat.
- wr_nonzero_data_i  in  BUS_SIZE*DAT_SIZE  packed nonzero-data slice.
- wr_dat_count_i  in  $clog2(BEAT_NUM)  beat index within the chunk.
- wr_chunk_count_i  in  $clog2(CHUNK_NUM)  target chunk.
- chunk_done_o  out  1  one-cycle pulse when a chunk completes.
- chunk_done_idx_o  out  $clog2(CHUNK_NUM)  index of the completed chunk.
- chunk_done_beats_o  out  $clog2(BEAT_NUM)+1  beats received for that chunk.
- chunk_done_nz_o  out  $clog2(BUS_SIZE*BEAT_NUM)+1  popcount of the chunk's sparsemap.
- chunk_ready_o  out  CHUNK_NUM  per-chunk ready bits.
- rd_release_i  in  1  releases the chunk selected by rd_chunk_i.
- rd_en_i  in  1  read request.
- rd_chunk_i  in  $clog2(CHUNK_NUM)  read chunk.
- rd_beat_i  in  $clog2(BEAT_NUM)  read beat.
- rd_valid_o  out  1  read data valid.
- rd_sparsemap_o  out  BUS_SIZE  read sparsemap.
- rd_nonzero_data_o  out  BUS_SIZE*DAT_SIZE  read data.
- seq_err_o  out  1  one-cycle pulse on a sequencing violation.
- ovw_err_o  out  1  one-cycle pulse on a write into a ready chunk.
- err_sticky_o  out  1  OR of all error pulses since reset.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE and all ready bits are cleared. Buffer contents are not reset.
- Storage address is chunk*BEAT_NUM+beat.
  - Each entry holds BUS_SIZE sparsemap bits plus BUS_SIZE*DAT_SIZE data bits.
  - Every beat with wr_valid_i=1 is written, including error beats.
- FSM states are IDLE and RECV.
  - Registered trackers: cur_chunk, exp_beat, beat_cnt, nz_acc.
- IDLE:
  - A valid beat with dat_count==0 moves to RECV, latches cur_chunk, sets exp_beat=1 and beat_cnt=1, and loads nz_acc with the beat's popcount.
  - A valid beat with dat_count!=0 pulses seq_err_o and stays in IDLE.
- RECV, a valid beat with dat_count==0 terminates the current chunk and starts a new chunk in the same cycle.
  - The new chunk may have the same or a different index.
  - Back-to-back chunks must not lose cycles.
- RECV, a valid beat with chunk==cur_chunk and dat_count==exp_beat is accepted: increment exp_beat and beat_cnt, add its popcount to nz_acc.
- RECV, any other valid beat:
  - Pulses seq_err_o.
  - Terminates the current chunk; the beat is not counted.
  - Moves to IDLE.
- RECV, wr_valid_i=0 terminates the current chunk and moves to IDLE.
- RECV, an accepted beat with dat_count==BEAT_NUM-1 terminates the chunk after that beat and moves to IDLE.
- Termination:
  - Registered outputs: chunk_done_o=1 on the following cycle with idx, beats and nz of the terminated chunk.
  - chunk_ready_o[idx] sets on that same edge.
- Overwrite: starting a chunk whose ready bit is 1 pulses ovw_err_o and clears that ready bit.
- Release: rd_release_i clears chunk_ready_o[rd_chunk_i].
  - Release and set of the same bit in the same cycle: set wins.
- Read: rd_en_i registers the request; data appears one cycle later.
  - Ready chunk: rd_valid_o=1 with the stored data.
  - Non-ready chunk: rd_valid_o=0 and both read data buses are 0.
  - A read of the chunk currently receiving beats returns the old contents.
- Asynchronous reset mid-chunk: no chunk_done_o pulse for the aborted chunk.

Optional Feature:
- Macro: NZ_COUNT_CHECK_EN.
- Defined:
  - An extra accumulator counts nonzero DAT_SIZE lanes across the chunk's data beats.
  - The output nz_mismatch_o is added. It pulses with chunk_done_o when that count differs from chunk_done_nz_o, and feeds err_sticky_o.
  - This catches packing errors and zero-valued data, e.g. the value 256 truncated to 0.
- Not defined: no port, no accumulator, zero area.

Decomposition:
- Package sparse_rx_pkg holds:
  - the rx_state_e enum {IDLE, RECV};
  - width localparams derived from BUS_SIZE/BEAT_NUM/CHUNK_NUM;
  - a popcount function.
- Sub-module sparse_rx_buf: 1R1W synchronous RAM with registered read, CHUNK_NUM*BEAT_NUM entries deep.

Test Plan:
- Chunk 0, beats 0..3 with sparsemap 16'h00FF each, valid held, then valid low -> chunk_done_o one cycle after the last beat with idx=0, beats=4, nz=32; chunk_ready_o=4'b0001.
- Chunk 1 beats 0,1, then chunk 2 beat 0 on the next cycle -> done for chunk 1 (beats=2) with no gap; chunk 2 accepted.
- Chunk 0 beats 0,2 -> seq_err_o on the beat-2 cycle; done with beats=1; err_sticky_o=1.
- Ready chunk 3 rewritten without release -> ovw_err_o=1; ready[3] clears, then re-sets on done. Release and done on chunk 3 in the same cycle -> ready[3]=1.
- Read chunk 0 beat 2 after ready -> next cycle rd_valid_o=1 with the written data. Read of non-ready chunk 2 -> rd_valid_o=0, data 0.
- With NZ_COUNT_CHECK_EN: sparsemap 16'h0003 with data lanes {8'h05, 8'h00} -> nz_mismatch_o pulses alongside chunk_done_o.

Source files
------------

// File: rtl/sparse_rx_pkg.sv
// Shared types, default geometry and popcount helper for the sparse chunk receiver.
package sparse_rx_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    localparam int BUS_SIZE_DEF  = 16;
    localparam int DAT_SIZE_DEF  = 8;
    localparam int CHUNK_NUM_DEF = 4;
    localparam int BEAT_NUM_DEF  = 4;

    localparam int CHUNK_W_DEF = $clog2(CHUNK_NUM_DEF);
    localparam int BEAT_W_DEF  = $clog2(BEAT_NUM_DEF);
    localparam int BEATS_W_DEF = BEAT_W_DEF + 1;
    localparam int NZ_W_DEF    = $clog2(BUS_SIZE_DEF * BEAT_NUM_DEF) + 1;

    // Widest sparsemap slice the popcount helper accepts; narrower slices are zero-extended.
    localparam int POP_MAX = 64;
    localparam int POP_W   = $clog2(POP_MAX) + 1;

    function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX-1:0] v);
        logic [POP_W-1:0] cnt;
        cnt = {POP_W{1'b0}};
        for (int i = 0; i < POP_MAX; i++) begin
            cnt = cnt + {{(POP_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sparse_rx_buf.sv
// Chunk buffer: 1R1W synchronous RAM with a registered read port (read-first on collision).
module sparse_rx_buf #(
    parameter int WIDTH = 144,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    // Storage array, deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_q <= {WIDTH{1'b0}};
        end else if (re_i) begin
            r_q <= r_mem[raddr_i];
        end
    end

    assign rdata_o = r_q;

endmodule

// File: rtl/sparse_chunk_sram_receiver.sv
// Receiver for compressed chunks: buffers beats, tracks sequencing, publishes chunk-ready status.
// Optional NZ_COUNT_CHECK_EN adds nz_mismatch_o comparing nonzero data lanes against the sparsemap popcount.
module sparse_chunk_sram_receiver
    import sparse_rx_pkg::*;
#(
    parameter int BUS_SIZE  = BUS_SIZE_DEF,
    parameter int DAT_SIZE  = DAT_SIZE_DEF,
    parameter int CHUNK_NUM = CHUNK_NUM_DEF,
    parameter int BEAT_NUM  = BEAT_NUM_DEF
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  wr_valid_i,
    input  logic [BUS_SIZE-1:0]                   wr_sparsemap_i,
    input  logic [BUS_SIZE*DAT_SIZE-1:0]          wr_nonzero_data_i,
    input  logic [$clog2(BEAT_NUM)-1:0]           wr_dat_count_i,
    input  logic [$clog2(CHUNK_NUM)-1:0]          wr_chunk_count_i,
    output logic                                  chunk_done_o,
    output logic [$clog2(CHUNK_NUM)-1:0]          chunk_done_idx_o,
    output logic [$clog2(BEAT_NUM):0]             chunk_done_beats_o,
    output logic [$clog2(BUS_SIZE*BEAT_NUM):0]    chunk_done_nz_o,
    output logic [CHUNK_NUM-1:0]                  chunk_ready_o,
    input  logic                                  rd_release_i,
    input  logic                                  rd_en_i,
    input  logic [$clog2(CHUNK_NUM)-1:0]          rd_chunk_i,
    input  logic [$clog2(BEAT_NUM)-1:0]           rd_beat_i,
    output logic                                  rd_valid_o,
    output logic [BUS_SIZE-1:0]                   rd_sparsemap_o,
    output logic [BUS_SIZE*DAT_SIZE-1:0]          rd_nonzero_data_o,
    output logic                                  seq_err_o,
    output logic                                  ovw_err_o,
`ifdef NZ_COUNT_CHECK_EN
    output logic                                  nz_mismatch_o,
`endif
    output logic                                  err_sticky_o
);

    localparam int CW = $clog2(CHUNK_NUM);
    localparam int BW = $clog2(BEAT_NUM);
    localparam int NW = $clog2(BUS_SIZE*BEAT_NUM) + 1;
    localparam int PW = $clog2(BUS_SIZE) + 1;
    localparam int DW = BUS_SIZE * DAT_SIZE;
    localparam int EW = BUS_SIZE + DW;
    localparam int AW = $clog2(CHUNK_NUM*BEAT_NUM);
    localparam logic [CHUNK_NUM-1:0] ONE_HOT0 = {{(CHUNK_NUM-1){1'b0}}, 1'b1};

    rx_state_e               r_state;
    rx_state_e               w_state_nxt;
    logic [CW-1:0]           r_cur_chunk;
    logic [BW-1:0]           r_exp_beat;
    logic [BW:0]             r_beat_cnt;
    logic [NW-1:0]           r_nz_acc;
    logic [CHUNK_NUM-1:0]    r_ready;
    logic [CHUNK_NUM-1:0]    w_ready_nxt;
    logic                    r_done, r_seq_err, r_ovw_err, r_sticky, r_rd_ok;
    logic [CW-1:0]           r_done_idx;
    logic [BW:0]             r_done_beats;
    logic [NW-1:0]           r_done_nz;
    logic                    w_start, w_accept, w_last, w_seq_err, w_term, w_ovw, w_mis;
    logic [PW-1:0]           w_pop;
    logic [BW:0]             w_fin_beats;
    logic [NW-1:0]           w_fin_nz;
    logic [EW-1:0]           w_rd_q;
    logic [AW-1:0]           w_waddr, w_raddr;

    assign w_pop   = PW'(popcount(POP_MAX'(wr_sparsemap_i)));
    assign w_waddr = AW'(wr_chunk_count_i) * AW'(BEAT_NUM) + AW'(wr_dat_count_i);
    assign w_raddr = AW'(rd_chunk_i) * AW'(BEAT_NUM) + AW'(rd_beat_i);

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = w_start ? RECV : IDLE;
            RECV: begin
                if (w_start) begin
                    w_state_nxt = RECV;
                end else if (w_accept && !w_last) begin
                    w_state_nxt = RECV;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM output decode: a dat_count==0 beat always opens a chunk and closes any open one.
    always_comb begin
        w_start   = wr_valid_i && (wr_dat_count_i == {BW{1'b0}});
        w_last    = (wr_dat_count_i == BW'(BEAT_NUM-1));
        w_accept  = 1'b0;
        w_seq_err = 1'b0;
        w_term    = 1'b0;
        case (r_state)
            IDLE: begin
                w_seq_err = wr_valid_i && !w_start;
            end
            RECV: begin
                w_accept  = wr_valid_i && !w_start && (wr_chunk_count_i == r_cur_chunk)
                            && (wr_dat_count_i == r_exp_beat);
                w_seq_err = wr_valid_i && !w_start && !w_accept;
                w_term    = !wr_valid_i || w_start || w_seq_err || (w_accept && w_last);
            end
            default: begin
                w_seq_err = 1'b0;
            end
        endcase
        w_ovw       = w_start && r_ready[wr_chunk_count_i];
        w_fin_beats = w_accept ? r_beat_cnt + (BW+1)'(1'b1) : r_beat_cnt;
        w_fin_nz    = w_accept ? r_nz_acc + NW'(w_pop) : r_nz_acc;
    end

`ifdef NZ_COUNT_CHECK_EN
    logic [PW-1:0] w_lnz;
    logic [NW-1:0] r_lnz_acc;
    logic [NW-1:0] w_fin_lnz;
    logic          r_nz_mis;

    // Count nonzero data lanes of the incoming beat.
    always_comb begin
        w_lnz = {PW{1'b0}};
        for (int i = 0; i < BUS_SIZE; i++) begin
            w_lnz = w_lnz + PW'(wr_nonzero_data_i[i*DAT_SIZE +: DAT_SIZE] != {DAT_SIZE{1'b0}});
        end
    end

    assign w_fin_lnz = w_accept ? r_lnz_acc + NW'(w_lnz) : r_lnz_acc;
    assign w_mis     = w_term && (w_fin_lnz != w_fin_nz);

    // Lane-count accumulator and mismatch pulse.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_lnz_acc <= {NW{1'b0}};
            r_nz_mis  <= 1'b0;
        end else begin
            r_nz_mis <= w_mis;
            if (w_start) begin
                r_lnz_acc <= NW'(w_lnz);
            end else if (w_accept) begin
                r_lnz_acc <= w_fin_lnz;
            end
        end
    end

    assign nz_mismatch_o = r_nz_mis;
`else
    assign w_mis = 1'b0;
`endif

    // Chunk trackers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cur_chunk <= {CW{1'b0}};
            r_exp_beat  <= {BW{1'b0}};
            r_beat_cnt  <= {(BW+1){1'b0}};
            r_nz_acc    <= {NW{1'b0}};
        end else if (w_start) begin
            r_cur_chunk <= wr_chunk_count_i;
            r_exp_beat  <= BW'(1'b1);
            r_beat_cnt  <= (BW+1)'(1'b1);
            r_nz_acc    <= NW'(w_pop);
        end else if (w_accept) begin
            r_exp_beat  <= r_exp_beat + BW'(1'b1);
            r_beat_cnt  <= w_fin_beats;
            r_nz_acc    <= w_fin_nz;
        end
    end

    // Ready bits: a completing chunk's set beats a release or overwrite clear.
    always_comb begin
        w_ready_nxt = r_ready;
        w_ready_nxt = w_ready_nxt & ~(rd_release_i ? (ONE_HOT0 << rd_chunk_i) : {CHUNK_NUM{1'b0}});
        w_ready_nxt = w_ready_nxt & ~(w_ovw ? (ONE_HOT0 << wr_chunk_count_i) : {CHUNK_NUM{1'b0}});
        w_ready_nxt = w_ready_nxt | (w_term ? (ONE_HOT0 << r_cur_chunk) : {CHUNK_NUM{1'b0}});
    end

    // Registered status, error and read-qualifier outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ready      <= {CHUNK_NUM{1'b0}};
            r_done       <= 1'b0;
            r_done_idx   <= {CW{1'b0}};
            r_done_beats <= {(BW+1){1'b0}};
            r_done_nz    <= {NW{1'b0}};
            r_seq_err    <= 1'b0;
            r_ovw_err    <= 1'b0;
            r_sticky     <= 1'b0;
            r_rd_ok      <= 1'b0;
        end else begin
            r_ready      <= w_ready_nxt;
            r_done       <= w_term;
            r_done_idx   <= w_term ? r_cur_chunk : {CW{1'b0}};
            r_done_beats <= w_term ? w_fin_beats : {(BW+1){1'b0}};
            r_done_nz    <= w_term ? w_fin_nz : {NW{1'b0}};
            r_seq_err    <= w_seq_err;
            r_ovw_err    <= w_ovw;
            r_sticky     <= r_sticky | w_seq_err | w_ovw | w_mis;
            r_rd_ok      <= rd_en_i && r_ready[rd_chunk_i];
        end
    end

    sparse_rx_buf #(
        .WIDTH (EW),
        .DEPTH (CHUNK_NUM*BEAT_NUM)
    ) u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (wr_valid_i),
        .waddr_i (w_waddr),
        .wdata_i ({wr_sparsemap_i, wr_nonzero_data_i}),
        .re_i    (rd_en_i),
        .raddr_i (w_raddr),
        .rdata_o (w_rd_q)
    );

    assign chunk_done_o       = r_done;
    assign chunk_done_idx_o   = r_done_idx;
    assign chunk_done_beats_o = r_done_beats;
    assign chunk_done_nz_o    = r_done_nz;
    assign chunk_ready_o      = r_ready;
    assign seq_err_o          = r_seq_err;
    assign ovw_err_o          = r_ovw_err;
    assign err_sticky_o       = r_sticky;
    assign rd_valid_o         = r_rd_ok;
    assign rd_sparsemap_o     = r_rd_ok ? w_rd_q[EW-1 -: BUS_SIZE] : {BUS_SIZE{1'b0}};
    assign rd_nonzero_data_o  = r_rd_ok ? w_rd_q[DW-1:0] : {DW{1'b0}};

endmodule

// File: tb/tb_sparse_chunk_sram_receiver.sv
// Table-driven bench for sparse_chunk_sram_receiver with write and read scoreboards.
module tb_sparse_chunk_sram_receiver;

    localparam int BUS = 16;
    localparam int DAT = 8;
    localparam int DW  = BUS * DAT;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           wr_valid_i = 1'b0;
    logic [15:0]    wr_sparsemap_i = 16'h0;
    logic [DW-1:0]  wr_nonzero_data_i = '0;
    logic [1:0]     wr_dat_count_i = 2'd0;
    logic [1:0]     wr_chunk_count_i = 2'd0;
    logic           chunk_done_o;
    logic [1:0]     chunk_done_idx_o;
    logic [2:0]     chunk_done_beats_o;
    logic [6:0]     chunk_done_nz_o;
    logic [3:0]     chunk_ready_o;
    logic           rd_release_i = 1'b0;
    logic           rd_en_i = 1'b0;
    logic [1:0]     rd_chunk_i = 2'd0;
    logic [1:0]     rd_beat_i = 2'd0;
    logic           rd_valid_o;
    logic [15:0]    rd_sparsemap_o;
    logic [DW-1:0]  rd_nonzero_data_o;
    logic           seq_err_o;
    logic           ovw_err_o;
    logic           err_sticky_o;
`ifdef NZ_COUNT_CHECK_EN
    logic           nz_mismatch_o;
`endif

    always #5 clk_i = ~clk_i;

    sparse_chunk_sram_receiver dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .wr_valid_i         (wr_valid_i),
        .wr_sparsemap_i     (wr_sparsemap_i),
        .wr_nonzero_data_i  (wr_nonzero_data_i),
        .wr_dat_count_i     (wr_dat_count_i),
        .wr_chunk_count_i   (wr_chunk_count_i),
        .chunk_done_o       (chunk_done_o),
        .chunk_done_idx_o   (chunk_done_idx_o),
        .chunk_done_beats_o (chunk_done_beats_o),
        .chunk_done_nz_o    (chunk_done_nz_o),
        .chunk_ready_o      (chunk_ready_o),
        .rd_release_i       (rd_release_i),
        .rd_en_i            (rd_en_i),
        .rd_chunk_i         (rd_chunk_i),
        .rd_beat_i          (rd_beat_i),
        .rd_valid_o         (rd_valid_o),
        .rd_sparsemap_o     (rd_sparsemap_o),
        .rd_nonzero_data_o  (rd_nonzero_data_o),
        .seq_err_o          (seq_err_o),
        .ovw_err_o          (ovw_err_o),
`ifdef NZ_COUNT_CHECK_EN
        .nz_mismatch_o      (nz_mismatch_o),
`endif
        .err_sticky_o       (err_sticky_o)
    );

    typedef struct {
        logic        v;
        logic [1:0]  ch;
        logic [1:0]  dc;
        logic [15:0] smap;
        logic        rel;
        logic [1:0]  rch;
        logic        e_done;
        logic [1:0]  e_idx;
        logic [2:0]  e_beats;
        logic [6:0]  e_nz;
        logic        e_seq;
        logic        e_ovw;
        logic        e_sticky;
        logic [3:0]  e_ready;
    } vec_t;

    typedef struct {
        logic          valid;
        logic [15:0]   smap;
        logic [DW-1:0] data;
    } rd_exp_t;

    vec_t    tbl[$];
    vec_t    sb[$];
    rd_exp_t rsb[$];
    int      n_tests = 0;
    int      n_fail  = 0;
    logic [15:0]   sh_smap [16];
    logic [DW-1:0] sh_data [16];

    function automatic vec_t mkv(input logic v, input int ch, input int dc, input logic [15:0] smap,
                                 input logic rel, input int rch, input logic e_done, input int e_idx,
                                 input int e_beats, input int e_nz, input logic e_seq, input logic e_ovw,
                                 input logic e_sticky, input logic [3:0] e_ready);
        vec_t r;
        r.v = v; r.ch = 2'(ch); r.dc = 2'(dc); r.smap = smap; r.rel = rel; r.rch = 2'(rch);
        r.e_done = e_done; r.e_idx = 2'(e_idx); r.e_beats = 3'(e_beats); r.e_nz = 7'(e_nz);
        r.e_seq = e_seq; r.e_ovw = e_ovw; r.e_sticky = e_sticky; r.e_ready = e_ready;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_row(input int i, input vec_t r);
        vec_t e;
        wr_valid_i        = r.v;
        wr_chunk_count_i  = r.ch;
        wr_dat_count_i    = r.dc;
        wr_sparsemap_i    = r.smap;
        wr_nonzero_data_i = {BUS{8'(8'h10 + i)}};
        rd_release_i      = r.rel;
        rd_chunk_i        = r.rch;
        if (r.v) begin
            sh_smap[r.ch*4 + r.dc] = r.smap;
            sh_data[r.ch*4 + r.dc] = {BUS{8'(8'h10 + i)}};
        end
        sb.push_back(r);
        tick();
        e = sb.pop_front();
        chk($sformatf("row%0d done", i), DW'(chunk_done_o), DW'(e.e_done));
        chk($sformatf("row%0d ready", i), DW'(chunk_ready_o), DW'(e.e_ready));
        chk($sformatf("row%0d seq_err", i), DW'(seq_err_o), DW'(e.e_seq));
        chk($sformatf("row%0d ovw_err", i), DW'(ovw_err_o), DW'(e.e_ovw));
        chk($sformatf("row%0d sticky", i), DW'(err_sticky_o), DW'(e.e_sticky));
        if (e.e_done) begin
            chk($sformatf("row%0d idx", i), DW'(chunk_done_idx_o), DW'(e.e_idx));
            chk($sformatf("row%0d beats", i), DW'(chunk_done_beats_o), DW'(e.e_beats));
            chk($sformatf("row%0d nz", i), DW'(chunk_done_nz_o), DW'(e.e_nz));
        end
    endtask

    task automatic rd(input int ch, input int bt, input logic exp_v);
        rd_exp_t e;
        e.valid = exp_v;
        e.smap  = exp_v ? sh_smap[ch*4 + bt] : 16'h0;
        e.data  = exp_v ? sh_data[ch*4 + bt] : {DW{1'b0}};
        rsb.push_back(e);
        rd_en_i = 1'b1; rd_chunk_i = 2'(ch); rd_beat_i = 2'(bt);
        tick();
        rd_en_i = 1'b0;
        e = rsb.pop_front();
        chk($sformatf("rd%0d.%0d valid", ch, bt), DW'(rd_valid_o), DW'(e.valid));
        chk($sformatf("rd%0d.%0d smap", ch, bt), DW'(rd_sparsemap_o), DW'(e.smap));
        chk($sformatf("rd%0d.%0d data", ch, bt), rd_nonzero_data_o, e.data);
    endtask

    initial begin
        rd_exp_t re;
        // v ch dc smap rel rch | done idx beats nz seq ovw sticky ready
        tbl.push_back(mkv(1, 0, 0, 16'h00FF, 0, 0,  0, 0, 0, 0,  0, 0, 0, 4'b0000));
        tbl.push_back(mkv(1, 0, 1, 16'h00FF, 0, 0,  0, 0, 0, 0,  0, 0, 0, 4'b0000));
        tbl.push_back(mkv(1, 0, 2, 16'h00FF, 0, 0,  0, 0, 0, 0,  0, 0, 0, 4'b0000));
        tbl.push_back(mkv(1, 0, 3, 16'h00FF, 0, 0,  1, 0, 4, 32, 0, 0, 0, 4'b0001));
        tbl.push_back(mkv(0, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 0,  0, 0, 0, 4'b0001));
        tbl.push_back(mkv(1, 1, 0, 16'h000F, 0, 0,  0, 0, 0, 0,  0, 0, 0, 4'b0001));
        tbl.push_back(mkv(1, 1, 1, 16'h0001, 0, 0,  0, 0, 0, 0,  0, 0, 0, 4'b0001));
        tbl.push_back(mkv(1, 2, 0, 16'h0003, 0, 0,  1, 1, 2, 5,  0, 0, 0, 4'b0011));
        tbl.push_back(mkv(0, 0, 0, 16'h0000, 0, 0,  1, 2, 1, 2,  0, 0, 0, 4'b0111));
        tbl.push_back(mkv(0, 0, 0, 16'h0000, 1, 0,  0, 0, 0, 0,  0, 0, 0, 4'b0110));
        tbl.push_back(mkv(1, 0, 0, 16'hFFFF, 0, 0,  0, 0, 0, 0,  0, 0, 0, 4'b0110));
        tbl.push_back(mkv(1, 0, 2, 16'h0001, 0, 0,  1, 0, 1, 16, 1, 0, 1, 4'b0111));
        tbl.push_back(mkv(1, 3, 0, 16'h0001, 0, 0,  0, 0, 0, 0,  0, 0, 1, 4'b0111));
        tbl.push_back(mkv(0, 0, 0, 16'h0000, 0, 0,  1, 3, 1, 1,  0, 0, 1, 4'b1111));
        tbl.push_back(mkv(1, 3, 0, 16'h0003, 0, 0,  0, 0, 0, 0,  0, 1, 1, 4'b0111));
        tbl.push_back(mkv(0, 0, 0, 16'h0000, 1, 3,  1, 3, 1, 2,  0, 0, 1, 4'b1111));
        tbl.push_back(mkv(1, 1, 1, 16'h0005, 0, 0,  0, 0, 0, 0,  1, 0, 1, 4'b1111));
        tbl.push_back(mkv(0, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 0,  0, 0, 1, 4'b1111));
        tbl.push_back(mkv(1, 2, 0, 16'h0000, 0, 0,  0, 0, 0, 0,  0, 1, 1, 4'b1011));
        tbl.push_back(mkv(1, 1, 1, 16'h0007, 0, 0,  1, 2, 1, 0,  1, 0, 1, 4'b1111));
        tbl.push_back(mkv(0, 0, 0, 16'h0000, 0, 0,  0, 0, 0, 0,  0, 0, 1, 4'b1111));

        #1 rst_i = 1'b0;
        repeat (2) tick();
        chk("reset done", DW'(chunk_done_o), DW'(1'b0));
        chk("reset ready", DW'(chunk_ready_o), DW'(4'b0000));
        chk("reset errs", DW'({seq_err_o, ovw_err_o, err_sticky_o}), DW'(3'b000));
        chk("reset rd", DW'({rd_valid_o, rd_sparsemap_o}), DW'(17'h0));
        chk("reset rd data", rd_nonzero_data_o, {DW{1'b0}});
        rst_i = 1'b1;
        tick();

        for (int i = 0; i < tbl.size(); i++) begin
            drive_row(i, tbl[i]);
        end

        rd(0, 2, 1'b1);
        rd(1, 1, 1'b1);
        rd_release_i = 1'b1; rd_chunk_i = 2'd2;
        tick();
        rd_release_i = 1'b0;
        chk("release2 ready", DW'(chunk_ready_o), DW'(4'b1011));
        rd(2, 0, 1'b0);

        // Read of a chunk in the same cycle its new data is written returns the old data.
        re.valid = 1'b1; re.smap = sh_smap[0]; re.data = sh_data[0];
        rsb.push_back(re);
        rd_en_i = 1'b1; rd_chunk_i = 2'd0; rd_beat_i = 2'd0;
        wr_valid_i = 1'b1; wr_chunk_count_i = 2'd0; wr_dat_count_i = 2'd0;
        wr_sparsemap_i = 16'h1234; wr_nonzero_data_i = {BUS{8'hA5}};
        sh_smap[0] = 16'h1234; sh_data[0] = {BUS{8'hA5}};
        tick();
        rd_en_i = 1'b0; wr_valid_i = 1'b0;
        re = rsb.pop_front();
        chk("rdw valid", DW'(rd_valid_o), DW'(re.valid));
        chk("rdw smap", DW'(rd_sparsemap_o), DW'(re.smap));
        chk("rdw data", rd_nonzero_data_o, re.data);
        chk("rdw ovw", DW'(ovw_err_o), DW'(1'b1));
        chk("rdw ready", DW'(chunk_ready_o), DW'(4'b1010));
        tick();
        chk("rdw done", DW'({chunk_done_o, chunk_done_idx_o, chunk_done_beats_o, chunk_done_nz_o}),
            DW'({1'b1, 2'd0, 3'd1, 7'd5}));
        chk("rdw ready2", DW'(chunk_ready_o), DW'(4'b1011));
        rd(0, 0, 1'b1);

        // Asynchronous reset mid-chunk: the aborted chunk never reports done.
        wr_valid_i = 1'b1; wr_chunk_count_i = 2'd1; wr_dat_count_i = 2'd0; wr_sparsemap_i = 16'h0001;
        tick();
        wr_valid_i = 1'b0;
        rst_i = 1'b0;
        #2;
        chk("arst done", DW'(chunk_done_o), DW'(1'b0));
        chk("arst ready", DW'(chunk_ready_o), DW'(4'b0000));
        chk("arst errs", DW'({seq_err_o, ovw_err_o, err_sticky_o, rd_valid_o}), DW'(4'b0000));
        tick();
        rst_i = 1'b1;
        tick();
        chk("arst no done", DW'(chunk_done_o), DW'(1'b0));
        tick();
        chk("arst no done2", DW'({chunk_done_o, chunk_ready_o}), DW'(5'b00000));

`ifdef NZ_COUNT_CHECK_EN
        wr_valid_i = 1'b1; wr_chunk_count_i = 2'd0; wr_dat_count_i = 2'd0;
        wr_sparsemap_i = 16'h0003; wr_nonzero_data_i = {DW{1'b0}};
        wr_nonzero_data_i[7:0] = 8'h05;
        tick();
        wr_valid_i = 1'b0;
        tick();
        chk("nzchk done", DW'({chunk_done_o, chunk_done_nz_o}), DW'({1'b1, 7'd2}));
        chk("nzchk mismatch", DW'(nz_mismatch_o), DW'(1'b1));
        chk("nzchk sticky", DW'(err_sticky_o), DW'(1'b1));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
